// File: rtl/pattern_sequencer_if.sv
// Configuration/control/status bundle for pattern_sequencer.
//   master: sequencer client (offers a load, drives start/stop, watches status/outputs)
//   slave : the sequencer itself
interface pattern_sequencer_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PAT_LEN  = 32,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned DIV_W    = 21
);
    localparam int unsigned PAT_W = CHANNELS * PAT_LEN;

    logic               load_valid;
    logic               load_ready;
    logic [PAT_W-1:0]   load_pattern;
    logic [LEN_W-1:0]   load_len;
    logic [DIV_W-1:0]   load_div;
    logic               load_oneshot;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   step_idx;
    logic [CHANNELS-1:0] out;

    modport master (
        output load_valid, load_pattern, load_len, load_div, load_oneshot, start, stop,
        input  load_ready, busy, done, step_idx, out
    );

    modport slave (
        input  load_valid, load_pattern, load_len, load_div, load_oneshot, start, stop,
        output load_ready, busy, done, step_idx, out
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Multi-channel pattern sequencer: each channel shows bit step_idx of its
// pattern while RUN; steps advance every div_reg+1 clocks, in loop or one-shot.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset
//   bus  - pattern_sequencer_if.slave: load handshake + config, start/stop,
//          busy/done/step_idx status and the channel outputs
module pattern_sequencer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PAT_LEN  = 32,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned DIV_W    = 21,
    parameter logic [CHANNELS*PAT_LEN-1:0] DEFAULT_PATTERN = {2{32'h0151_DDC5}},
    parameter logic [DIV_W-1:0]            DEFAULT_DIV     = DIV_W'(2**21-1),
    parameter bit                          AUTOSTART       = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    pattern_sequencer_if.slave   bus
);
    localparam int unsigned PAT_W = CHANNELS * PAT_LEN;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [PAT_W-1:0]    pat_reg, pat_nxt;
    logic [LEN_W-1:0]    len_reg, len_nxt;
    logic [DIV_W-1:0]    div_reg, div_nxt;
    logic                oneshot_reg, oneshot_nxt;
    logic [LEN_W-1:0]    step_idx_q, step_nxt;
    logic [DIV_W-1:0]    prescaler, pre_nxt;
    logic                done_q, done_nxt;

    logic                load_fire;
    logic [LEN_W-1:0]    len_in;
    logic [LEN_W-1:0]    last_step;
    logic [CHANNELS-1:0] out_c;
    logic [PAT_LEN-1:0]  ch_pat;
    logic [PAT_LEN-1:0]  ch_shift;

    assign load_fire = bus.load_valid && (state == IDLE);
    assign last_step = len_reg - LEN_W'(1);

    // Out-of-range lengths (0 or beyond PAT_LEN) collapse to the full pattern.
    assign len_in = (bus.load_len == '0 || bus.load_len > LEN_W'(PAT_LEN))
                  ? LEN_W'(PAT_LEN) : bus.load_len;

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= AUTOSTART ? RUN : IDLE;
            pat_reg     <= DEFAULT_PATTERN;
            len_reg     <= LEN_W'(PAT_LEN);
            div_reg     <= DEFAULT_DIV;
            oneshot_reg <= 1'b0;
            step_idx_q  <= '0;
            prescaler   <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pat_reg     <= pat_nxt;
            len_reg     <= len_nxt;
            div_reg     <= div_nxt;
            oneshot_reg <= oneshot_nxt;
            step_idx_q  <= step_nxt;
            prescaler   <= pre_nxt;
            done_q      <= done_nxt;
        end
    end

    // Next-state: config capture, start/stop, prescaler and step advance.
    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat_reg;
        len_nxt     = len_reg;
        div_nxt     = div_reg;
        oneshot_nxt = oneshot_reg;
        step_nxt    = step_idx_q;
        pre_nxt     = prescaler;
        done_nxt    = 1'b0;

        if (load_fire) begin
            pat_nxt     = bus.load_pattern;
            len_nxt     = len_in;
            div_nxt     = bus.load_div;
            oneshot_nxt = bus.load_oneshot;
        end

        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                    pre_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    pre_nxt   = '0;
                end else if (prescaler == div_reg) begin
                    pre_nxt = '0;
                    if (step_idx_q == last_step) begin
                        step_nxt = '0;
                        if (oneshot_reg) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        step_nxt = step_idx_q + LEN_W'(1);
                    end
                end else begin
                    pre_nxt = prescaler + DIV_W'(1);
                end
            end
        endcase
    end

    // Channel decode straight from registers; forced low outside RUN.
    always_comb begin
        out_c    = '0;
        ch_pat   = '0;
        ch_shift = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            ch_pat   = pat_reg[c*PAT_LEN +: PAT_LEN];
            ch_shift = ch_pat >> step_idx_q;
            out_c[c] = (state == RUN) & ch_shift[0];
        end
    end

    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state == RUN);
    assign bus.done       = done_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.out        = out_c;

endmodule
